mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencer for an iterative shift-add multiplier in the EX stage of the 5-stage RISC-V pipeline.
- Detects a MUL control code from the Control block on the instruction in EX.
- Stalls IF/ID/EX while the product is computed over WIDTH cycles, then presents the low WIDTH bits of the product for one cycle.
- Honours pipeline flush.

Parameters:
WIDTH, 32, operand/result width in bits.
CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset, synchronous, active-high.
ctrl_i  input  4  EX-stage control code (Ctrl_* encoding).
ex_valid_i  input  1  EX stage holds a valid (non-bubble) instruction.
flush_i  input  1  kill the EX instruction (branch taken); aborts any multiply in progress.
op_a_i  input  WIDTH  multiplicand (rs1 data after forwarding).
op_b_i  input  WIDTH  multiplier (rs2 data after forwarding).
stall_o  output  1  freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM.
busy_o  output  1  FSM not in IDLE.
result_o  output  WIDTH  product[WIDTH-1:0]; valid only while result_valid_o is high.
result_valid_o  output  1  one-cycle pulse; EX/MEM captures result_o as ALU result.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE. Accumulator, shifted operands and counter cleared. stall_o=0, busy_o=0, result_valid_o=0, result_o=0.
- start = ex_valid_i && ctrl_i==Ctrl_MUL && !flush_i && state==IDLE.
- stall_o = start || state==RUN. It is combinational, so it asserts in the detect cycle.
- busy_o = (state != IDLE).
- States:
  - IDLE: on start, latch a=op_a_i, b=op_b_i, acc=0, cnt=0 -> RUN. Otherwise stay in IDLE.
  - RUN: each cycle, if b[0] then acc += a (mod 2^WIDTH); a <<= 1; b >>= 1; cnt++. When cnt==WIDTH-1 -> DONE. Otherwise stay in RUN.
  - DONE: result_valid_o=1, result_o=acc, stall_o=0, so the pipeline advances this cycle. ctrl_i is ignored, because it is still the completed instruction. Next state is unconditionally IDLE.
- Latency: detect cycle + WIDTH RUN cycles = WIDTH+1 stalled cycles. result_valid_o occurs in cycle WIDTH+1 after detect (detect = cycle 0).
- Arithmetic: all adds and shifts truncate to WIDTH; the upper half of the product is discarded. Signedness is irrelevant for the low half.
- flush_i in RUN or DONE: next state IDLE, no result_valid_o pulse. stall_o drops combinationally in the flush cycle.
- flush_i in the detect cycle suppresses start.
- rst_i mid-operation: returns to reset values next edge regardless of state.
- Back-to-back MUL: the second MUL reaches EX in the cycle after DONE, sees IDLE, and restarts normally. There are no idle gaps beyond the DONE cycle.
- Non-MUL codes and bubbles (ex_valid_i=0) never stall; all outputs hold their idle values.
- result_o is held at the last value outside DONE. Consumers must qualify it with result_valid_o.

Optional Feature:
- Macro MUL_SEQ_EARLY_EXIT_EN.
- Defined: RUN also exits to DONE when (b>>1)==0 after the current step. Stalled cycles = 1 + max(1, bit-length of op_b).
- Undefined: fixed WIDTH iterations. Results are identical in both modes; only timing differs.

Decomposition:
- Ctrl_* codes come from the shared opcodes.vh, including Ctrl_MUL.
- Add to that header: the state encoding (MSEQ_IDLE=2'd0, MSEQ_RUN=2'd1, MSEQ_DONE=2'd2) and the default WIDTH.
- One sub-module, mul_shift_add_dp: a/b/acc registers plus adder and shifters, with load/step enables from the FSM.
- The FSM, counter and stall logic stay in mul_seq_ctrl.

Test Plan:
- 3*5, MUL held in EX, macro off: stall_o high cycles 0..32 (33 cycles); cycle 33: result_valid_o=1, result_o=15, stall_o=0.
- 0xFFFFFFFF*2: result_o=0xFFFFFFFE (truncation); 0x80000000*0x80000000: result_o=0.
- flush_i pulsed at RUN cycle 10: stall_o=0 in that cycle, busy_o=0 next cycle, no result_valid_o pulse; a following ADD (Ctrl_ADD) causes no stall.
- Two consecutive MULs (6*7 then 9*9): valid pulses with 42 then 81; second detect occurs in the cycle right after the first DONE.
- rst_i asserted at RUN cycle 5: all outputs 0 next edge. Non-MUL codes and ex_valid_i=0 with ctrl_i=Ctrl_MUL: stall_o stays 0.
- MUL_SEQ_EARLY_EXIT_EN defined:
  - 7*3: stall 3 cycles, result 21 at cycle 3.
  - 9*0: stall 2 cycles, result 0 at cycle 2.
  - 1*0x80000000: full 33-cycle stall, result 0x80000000.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the iterative multiplier sequencer: EX-stage control
// codes, the sequencer state encoding and the default operand width.
package mul_seq_ctrl_pkg;

    localparam int MSEQ_WIDTH_DEFAULT = 32;

    localparam logic [3:0] Ctrl_ADD  = 4'd0;
    localparam logic [3:0] Ctrl_SUB  = 4'd1;
    localparam logic [3:0] Ctrl_AND  = 4'd2;
    localparam logic [3:0] Ctrl_OR   = 4'd3;
    localparam logic [3:0] Ctrl_XOR  = 4'd4;
    localparam logic [3:0] Ctrl_SLL  = 4'd5;
    localparam logic [3:0] Ctrl_SRL  = 4'd6;
    localparam logic [3:0] Ctrl_SRA  = 4'd7;
    localparam logic [3:0] Ctrl_SLT  = 4'd8;
    localparam logic [3:0] Ctrl_SLTU = 4'd9;
    localparam logic [3:0] Ctrl_MUL  = 4'd10;

    typedef enum logic [1:0] {
        MSEQ_IDLE = 2'd0,
        MSEQ_RUN  = 2'd1,
        MSEQ_DONE = 2'd2
    } mseq_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage bundle between the pipeline (master) and the multiply sequencer (slave).
interface mul_seq_ctrl_if
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = MSEQ_WIDTH_DEFAULT
);
    // Handshake: the pipeline offers an instruction whenever ex_valid_i is high;
    // stall_o is the back-pressure (instruction not accepted while high), and
    // result_valid_o is a one-cycle pulse marking the only cycle result_o is meaningful.
    logic [3:0]       ctrl_i;
    logic             ex_valid_i;
    logic             flush_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] result_o;
    logic             result_valid_o;
    mseq_state_t      dbg_state;

    modport master (
        output ctrl_i, ex_valid_i, flush_i, op_a_i, op_b_i,
        input  stall_o, busy_o, result_o, result_valid_o, dbg_state
    );

    modport slave (
        input  ctrl_i, ex_valid_i, flush_i, op_a_i, op_b_i,
        output stall_o, busy_o, result_o, result_valid_o, dbg_state
    );

endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: multiplicand, multiplier and accumulator registers.
// With MUL_SEQ_EARLY_EXIT_EN defined, exit_ok flags that no multiplier bits remain.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic             exit_ok
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (load) begin
            a_q   <= op_a;
            b_q   <= op_b;
            acc_q <= '0;
        end else if (step) begin
            // Widths match, so the add and shift wrap to the low half of the product.
            if (b_q[0]) acc_q <= acc_q + a_q;
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
        end
    end

    assign acc = acc_q;

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign exit_ok = ((b_q >> 1) == '0);
`else
    assign exit_ok = 1'b0;
`endif

endmodule

// File: rtl/mul_seq_ctrl.sv
// EX-stage multiply sequencer: detects MUL, stalls the front of the pipe for the
// iterations and pulses the low product half. Timing option: MUL_SEQ_EARLY_EXIT_EN.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = MSEQ_WIDTH_DEFAULT,
    parameter int CNT_W = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mul_seq_ctrl_if.slave  bus
);

    mseq_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] acc;
    logic             exit_ok;
    logic             start;
    logic             last_step;
    logic             load;
    logic             step;
    logic             stall;
    logic             rvalid;

    assign start     = bus.ex_valid_i && (bus.ctrl_i == Ctrl_MUL) && !bus.flush_i
                       && (state_q == MSEQ_IDLE);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || exit_ok;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        stall   = 1'b0;
        rvalid  = 1'b0;
        case (state_q)
            MSEQ_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    stall   = 1'b1;
                    state_d = MSEQ_RUN;
                end
            end
            MSEQ_RUN: begin
                if (bus.flush_i) begin
                    state_d = MSEQ_IDLE;
                end else begin
                    step  = 1'b1;
                    stall = 1'b1;
                    if (last_step) state_d = MSEQ_DONE;
                end
            end
            MSEQ_DONE: begin
                // ctrl_i still shows the finished MUL here, so it must not restart.
                rvalid  = !bus.flush_i;
                state_d = MSEQ_IDLE;
            end
            default: state_d = MSEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MSEQ_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load)        cnt_q <= '0;
            else if (step)   cnt_q <= cnt_q + 1'b1;
            if (rvalid)      result_q <= acc;
        end
    end

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load),
        .step    (step),
        .op_a    (bus.op_a_i),
        .op_b    (bus.op_b_i),
        .acc     (acc),
        .exit_ok (exit_ok)
    );

    assign bus.stall_o        = stall;
    assign bus.busy_o         = (state_q != MSEQ_IDLE);
    assign bus.result_valid_o = rvalid;
    assign bus.result_o       = rvalid ? acc : result_q;
    assign bus.dbg_state      = state_q;

endmodule
